// File: rtl/hiscore_pkg.sv
// hiscore_pkg
//   Types and widths shared between the hiscore engine and the RAM port
//   that answers it inside the game core.
//   - HS_ADDR_W / HS_DATA_W : default RAM address and data widths.
//   - hs_port_state_t       : arbitration states of hiscore_ram_port.
package hiscore_pkg;

    localparam int HS_ADDR_W = 12;
    localparam int HS_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRAIN   = 2'd1,
        GRANT   = 2'd2,
        RELEASE = 2'd3
    } hs_port_state_t;

endpackage

// File: rtl/hs_drain_counter.sv
// hs_drain_counter
//   Counts clock-enable pulses while the CPU bus drains. tc_o flags the
//   enable pulse that completes N counts, so the owner can move on at
//   that same edge.
//   Ports:
//     clk, reset_n : clock, asynchronous active-low reset
//     count_en_i   : advance by one on this clk
//     clear_i      : synchronous clear, wins over count_en_i
//     tc_o         : this enable pulse is the N-th one
module hs_drain_counter #(
    parameter int N = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic count_en_i,
    input  logic clear_i,
    output logic tc_o
);

    localparam int CW = $clog2(N + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign tc_o = count_en_i && (count_q == CW'(N - 1));

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (count_en_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/hiscore_ram_port.sv
// hiscore_ram_port
//   Shares the game's work/score RAM between the Z80 bus and the hiscore
//   engine. A hiscore request pauses the CPU, lets the in-flight bus cycle
//   drain for DRAIN_CYCLES ena_6 pulses, then hands the RAM port over.
//   Ports:
//     clk, reset_n, ena_6                 : clock, async reset, 6 MHz enable
//     hs_access/hs_address/hs_data_in/hs_write : hiscore engine request side
//     hs_data_out/hs_ready/hs_err         : hiscore engine response side
//     cpu_hold                            : CPU pause request
//     cpu_addr/cpu_wdata/cpu_we/cpu_cs    : Z80 RAM access
//     ram_addr/ram_wdata/ram_we/ram_rdata : synchronous RAM, 1-clk read
//     dbg_state_o                         : current arbitration state
//
//   Handshake: hs_access is a level request held for the whole session.
//   hs_ready is high exactly while the port is granted; only then are
//   hs_address and hs_write honoured. Dropping hs_access ends the session
//   and hs_ready falls on the same edge the release begins.
module hiscore_ram_port
    import hiscore_pkg::*;
#(
    parameter int ADDR_W       = HS_ADDR_W,
    parameter int DATA_W       = HS_DATA_W,
    parameter int RAM_DEPTH    = 4096,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ena_6,
    input  logic              hs_access,
    input  logic [ADDR_W-1:0] hs_address,
    input  logic [DATA_W-1:0] hs_data_in,
    input  logic              hs_write,
    output logic [DATA_W-1:0] hs_data_out,
    output logic              hs_ready,
    output logic              hs_err,
    output logic              cpu_hold,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_we,
    input  logic              cpu_cs,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [1:0]        dbg_state_o
);

    // One extra bit so a depth equal to 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(RAM_DEPTH);

    hs_port_state_t    state_q, state_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              hs_ready_q, hs_ready_d;
    logic              hs_err_q, hs_err_d;
    logic [DATA_W-1:0] hs_data_out_q, hs_data_out_d;

    logic drain_en;
    logic drain_clr;
    logic drain_tc;
    logic hs_in_range;

    assign hs_in_range = ({1'b0, hs_address} < DEPTH_L);
    assign drain_en    = (state_q == DRAIN) && ena_6;
    // Any exit from DRAIN (or not being in it) leaves the counter at zero.
    assign drain_clr   = (state_q != DRAIN) || !hs_access || drain_tc;

    hs_drain_counter #(
        .N(DRAIN_CYCLES)
    ) u_drain (
        .clk       (clk),
        .reset_n   (reset_n),
        .count_en_i(drain_en),
        .clear_i   (drain_clr),
        .tc_o      (drain_tc)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (hs_access) state_d = DRAIN;
            DRAIN: begin
                if (!hs_access) begin
                    state_d = RELEASE;
                end else if (drain_tc) begin
                    state_d = GRANT;
                end
            end
            GRANT:   if (!hs_access) state_d = RELEASE;
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Flags are registered from the next state so they change on the
        // same edge as the state and cannot glitch.
        cpu_hold_d    = (state_d != IDLE);
        hs_ready_d    = (state_d == GRANT);
        hs_err_d      = hs_err_q | (hs_write & ((state_q != GRANT) | !hs_in_range));
        hs_data_out_d = (state_q == GRANT) ? ram_rdata : hs_data_out_q;
    end

    // RAM mux: combinational so the CPU path adds no latency. Keyed on the
    // state register, so an async reset returns the port to the CPU at once.
    always_comb begin
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
        ram_we    = cpu_we & cpu_cs;
        case (state_q)
            GRANT: begin
                ram_addr  = hs_address;
                ram_wdata = hs_data_in;
                ram_we    = hs_write & hs_in_range;
            end
            RELEASE: ram_we = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cpu_hold_q    <= 1'b0;
            hs_ready_q    <= 1'b0;
            hs_err_q      <= 1'b0;
            hs_data_out_q <= '0;
        end else begin
            state_q       <= state_d;
            cpu_hold_q    <= cpu_hold_d;
            hs_ready_q    <= hs_ready_d;
            hs_err_q      <= hs_err_d;
            hs_data_out_q <= hs_data_out_d;
        end
    end

    assign cpu_hold    = cpu_hold_q;
    assign hs_ready    = hs_ready_q;
    assign hs_err      = hs_err_q;
    assign hs_data_out = hs_data_out_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_hiscore_ram_port.sv
// tb_hiscore_ram_port
//   Directed bench for hiscore_ram_port with RAM_DEPTH=2048. A behavioural
//   model of the arbitration rules runs beside the DUT and is compared on
//   every clock outside reset; literal checks in the sequence pin the model.
module tb_hiscore_ram_port;

    localparam int AW    = 12;
    localparam int DW    = 8;
    localparam int DEPTH = 2048;
    localparam int DRAIN = 4;

    // ---------------- clock / reset / enable ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic          ena_6;
    logic          hs_access;
    logic [AW-1:0] hs_address;
    logic [DW-1:0] hs_data_in;
    logic          hs_write;
    logic [DW-1:0] hs_data_out;
    logic          hs_ready;
    logic          hs_err;
    logic          cpu_hold;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_we;
    logic          cpu_cs;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_we;
    logic [DW-1:0] ram_rdata = '0;
    logic [1:0]    dbg_state;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    assign ena_6 = (cyc[1:0] == 2'd0);

    hiscore_ram_port #(
        .ADDR_W(AW), .DATA_W(DW), .RAM_DEPTH(DEPTH), .DRAIN_CYCLES(DRAIN)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ena_6(ena_6),
        .hs_access(hs_access), .hs_address(hs_address), .hs_data_in(hs_data_in),
        .hs_write(hs_write), .hs_data_out(hs_data_out), .hs_ready(hs_ready),
        .hs_err(hs_err), .cpu_hold(cpu_hold), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_cs(cpu_cs),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .ram_rdata(ram_rdata), .dbg_state_o(dbg_state)
    );

    // Synchronous RAM seen by the DUT (read-before-write, 1-clk latency).
    logic [DW-1:0] ram_mem [0:4095] = '{default: 8'h00};
    always @(posedge clk) begin
        ram_rdata <= ram_mem[ram_addr];
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    end

    // ---------------- behavioural model ----------------
    logic          m_hold = 1'b0;     // CPU is paused
    logic          m_granted = 1'b0;  // hiscore engine owns the RAM
    logic          m_release = 1'b0;  // one-clk handback in progress
    logic          m_err = 1'b0;
    int            m_pulses = 0;      // ena_6 pulses seen while waiting
    logic [DW-1:0] m_dout = '0;
    logic [DW-1:0] rd_model = '0;
    logic [DW-1:0] exp_mem [0:4095] = '{default: 8'h00};
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    logic          exp_we;

    always_comb begin
        exp_addr  = cpu_addr;
        exp_wdata = cpu_wdata;
        exp_we    = cpu_we && cpu_cs && !m_release;
        if (m_granted) begin
            exp_addr  = hs_address;
            exp_wdata = hs_data_in;
            exp_we    = hs_write && (int'(hs_address) < DEPTH);
        end
    end

    always @(posedge clk) begin
        rd_model <= exp_mem[exp_addr];
        if (exp_we) exp_mem[exp_addr] <= exp_wdata;
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_hold    <= 1'b0;
            m_granted <= 1'b0;
            m_release <= 1'b0;
            m_err     <= 1'b0;
            m_pulses  <= 0;
            m_dout    <= '0;
        end else begin
            if (hs_write && (!m_granted || int'(hs_address) >= DEPTH)) m_err <= 1'b1;
            if (m_granted) m_dout <= rd_model;
            if (m_release) begin
                m_release <= 1'b0;
                m_hold    <= 1'b0;
            end else if (m_granted) begin
                if (!hs_access) begin
                    m_granted <= 1'b0;
                    m_release <= 1'b1;
                end
            end else if (m_hold) begin
                if (!hs_access) begin
                    m_release <= 1'b1;
                    m_pulses  <= 0;
                end else if (ena_6) begin
                    if (m_pulses + 1 == DRAIN) begin
                        m_granted <= 1'b1;
                        m_pulses  <= 0;
                    end else begin
                        m_pulses <= m_pulses + 1;
                    end
                end
            end else if (hs_access) begin
                m_hold   <= 1'b1;
                m_pulses <= 0;
            end
        end
    end

    // ---------------- scoreboard ----------------
    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("m_ram_addr", 32'(ram_addr), 32'(exp_addr));
        check("m_ram_wdata", 32'(ram_wdata), 32'(exp_wdata));
        check("m_ram_we", 32'(ram_we), 32'(exp_we));
        check("m_cpu_hold", 32'(cpu_hold), 32'(m_hold));
        check("m_hs_ready", 32'(hs_ready), 32'(m_granted));
        check("m_hs_err", 32'(hs_err), 32'(m_err));
        check("m_hs_data_out", 32'(hs_data_out), 32'(m_dout));
        check("m_state_busy", 32'(dbg_state != 2'd0), 32'(m_hold));
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic align_ena();
        while (cyc[1:0] != 2'd0) tick();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        check("rst_err_clear", 32'(hs_err), 32'd0);
        reset_n = 1'b1;
        tick();
    endtask

    // Raise hs_access in the cycle where ena_6 is high: the IDLE edge
    // ignores that pulse, then pulses land on edges 5, 9, 13 and 17.
    task automatic grant_seq();
        int lat;
        align_ena();
        check("pre_req_hold", 32'(cpu_hold), 32'd0);
        hs_access = 1'b1;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            lat++;
            if (lat == 1) check("hold_latency", 32'(cpu_hold), 32'd1);
            if (hs_ready) break;
        end
        check("grant_latency", 32'(lat), 32'd17);
    endtask

    // ---------------- sequence ----------------
    initial begin
        reset_n = 1'b0; hs_access = 1'b0; hs_address = '0; hs_data_in = '0;
        hs_write = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0; cpu_cs = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (reset_n) compare_all();
            end
        join_none

        repeat (3) tick();
        check("rst_hold", 32'(cpu_hold), 32'd0);
        check("rst_ready", 32'(hs_ready), 32'd0);
        check("rst_err", 32'(hs_err), 32'd0);
        check("rst_dout", 32'(hs_data_out), 32'd0);
        reset_n = 1'b1;
        tick();

        // Idle passthrough
        cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h123; cpu_wdata = 8'h5A;
        #1;
        check("idle_we", 32'(ram_we), 32'd1);
        check("idle_addr", 32'(ram_addr), 32'h123);
        check("idle_wdata", 32'(ram_wdata), 32'h5A);
        check("idle_hold", 32'(cpu_hold), 32'd0);
        tick();
        cpu_cs = 1'b0;
        #1;
        check("idle_no_cs", 32'(ram_we), 32'd0);
        cpu_cs = 1'b1; cpu_we = 1'b0;
        tick();

        // Grant, then hiscore write with a competing CPU write
        grant_seq();
        hs_address = 12'h0F0; hs_data_in = 8'hA5; hs_write = 1'b1;
        cpu_we = 1'b1; cpu_addr = 12'h055; cpu_wdata = 8'h33;
        #1;
        check("hs_wr_we", 32'(ram_we), 32'd1);
        check("hs_wr_addr", 32'(ram_addr), 32'h0F0);
        check("hs_wr_data", 32'(ram_wdata), 32'hA5);
        tick();
        hs_write = 1'b0;
        #1;
        check("cpu_we_blocked", 32'(ram_we), 32'd0);
        tick();
        check("rd_not_yet", 32'(hs_data_out), 32'h00);
        tick();
        check("rd_a5", 32'(hs_data_out), 32'hA5);
        cpu_we = 1'b0;
        hs_address = 12'h123;
        tick();
        tick();
        check("rd_5a", 32'(hs_data_out), 32'h5A);

        // Release from GRANT
        hs_access = 1'b0;
        tick();
        check("rel_ready", 32'(hs_ready), 32'd0);
        check("rel_hold", 32'(cpu_hold), 32'd1);
        cpu_we = 1'b1;
        #1;
        check("rel_we", 32'(ram_we), 32'd0);
        tick();
        check("rel_idle_hold", 32'(cpu_hold), 32'd0);
        check("rel_idle_we", 32'(ram_we), 32'd1);
        cpu_we = 1'b0;
        tick();

        // Abort after two drain pulses, re-request during RELEASE
        align_ena();
        hs_access = 1'b1;
        repeat (9) tick();
        hs_access = 1'b0;
        tick();
        check("abort_rel_hold", 32'(cpu_hold), 32'd1);
        check("abort_no_ready", 32'(hs_ready), 32'd0);
        hs_access = 1'b1;
        tick();
        check("abort_idle_gap", 32'(cpu_hold), 32'd0);
        tick();
        check("rereq_hold", 32'(cpu_hold), 32'd1);
        hs_access = 1'b0;
        tick();
        tick();
        check("abort_idle", 32'(cpu_hold), 32'd0);

        // Out-of-range write in GRANT
        do_reset();
        grant_seq();
        hs_address = 12'hFFF; hs_data_in = 8'hEE; hs_write = 1'b1;
        #1;
        check("oor_we", 32'(ram_we), 32'd0);
        tick();
        check("oor_err", 32'(hs_err), 32'd1);
        hs_address = 12'h7FF; hs_data_in = 8'h11;
        #1;
        check("last_valid_we", 32'(ram_we), 32'd1);
        tick();
        hs_write = 1'b0;
        check("oor_err_sticky", 32'(hs_err), 32'd1);
        hs_access = 1'b0;
        tick();
        tick();

        // Write while not granted
        do_reset();
        hs_write = 1'b1; hs_address = 12'h010;
        #1;
        check("idle_hs_we", 32'(ram_we), 32'd0);
        tick();
        check("idle_err", 32'(hs_err), 32'd1);
        hs_write = 1'b0;
        repeat (5) tick();
        check("idle_err_sticky", 32'(hs_err), 32'd1);
        reset_n = 1'b0;
        #1;
        check("err_async_clr", 32'(hs_err), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // Async reset mid-GRANT
        grant_seq();
        hs_address = 12'h020; hs_data_in = 8'h77; hs_write = 1'b1;
        cpu_we = 1'b0; cpu_addr = 12'h321;
        #1;
        check("pre_rst_we", 32'(ram_we), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check("arst_we", 32'(ram_we), 32'd0);
        check("arst_ready", 32'(hs_ready), 32'd0);
        check("arst_hold", 32'(cpu_hold), 32'd0);
        check("arst_addr", 32'(ram_addr), 32'h321);
        hs_write = 1'b0; hs_access = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        cpu_we = 1'b1; cpu_addr = 12'h456; cpu_wdata = 8'h9C;
        #1;
        check("post_rst_we", 32'(ram_we), 32'd1);
        check("post_rst_addr", 32'(ram_addr), 32'h456);
        tick();
        cpu_we = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/hiscore_ram_port.md
Name: hiscore_ram_port

Overview:
- Responder side of the hiscore RAM-access protocol; instantiated inside the game core.
- Arbitrates the game's work/score RAM between the Z80 bus and the hiscore engine.
- On an `hs_access` request it holds the CPU, waits for the in-flight bus cycle to drain, then grants the RAM port to the hiscore engine.
- Serves hiscore reads and writes, then returns the RAM to the CPU cleanly.

Parameters:
- ADDR_W, 12, RAM address width (matches the hiscore engine address width).
- DATA_W, 8, RAM data width.
- RAM_DEPTH, 4096, number of valid words; hiscore writes at or above this are dropped.
- DRAIN_CYCLES, 4, `ena_6` pulses counted after `cpu_hold` asserts before grant.

Ports:
- clk  in  1  system clock, 24 MHz.
- reset_n  in  1  asynchronous active-low reset.
- ena_6  in  1  6 MHz clock-enable, one clk wide.
- hs_access  in  1  hiscore engine requests the RAM (level).
- hs_address  in  ADDR_W  hiscore address.
- hs_data_in  in  DATA_W  hiscore write data.
- hs_write  in  1  hiscore write strobe (level, one word per clk).
- hs_data_out  out  DATA_W  registered read data to the hiscore engine.
- hs_ready  out  1  grant active; hiscore address and strobe are honoured.
- hs_err  out  1  sticky: `hs_write` seen while not granted, or out of range.
- cpu_hold  out  1  pause request into the CPU clock-enable gating.
- cpu_addr  in  ADDR_W  CPU RAM address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_we  in  1  CPU write.
- cpu_cs  in  1  CPU RAM chip-select.
- ram_addr  out  ADDR_W  to the synchronous RAM (1-clk read latency).
- ram_wdata  out  DATA_W  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_rdata  in  DATA_W  RAM read data; also wired directly to the CPU data-in mux outside this block.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE.
  - cpu_hold=0, hs_ready=0, hs_err=0, hs_data_out=0.
  - drain counter=0.
  - RAM mux selects CPU.
- FSM states: IDLE, DRAIN, GRANT, RELEASE.
- IDLE:
  - ram_addr=cpu_addr, ram_wdata=cpu_wdata, ram_we=cpu_we&cpu_cs. This path is combinational, with zero added latency.
  - hs_access=1 -> DRAIN; cpu_hold=1 from the next clk.
- DRAIN:
  - CPU path still muxed, so the in-flight CPU write completes.
  - Counter increments on each ena_6.
  - Counter reaches DRAIN_CYCLES -> GRANT, counter cleared.
  - hs_access=0 during DRAIN -> RELEASE (abort, no grant).
- GRANT:
  - hs_ready=1.
  - ram_addr=hs_address, ram_wdata=hs_data_in.
  - ram_we=hs_write & (hs_address<RAM_DEPTH).
  - CPU writes are blocked.
  - hs_data_out <= ram_rdata every clk, so data is valid 2 clk after hs_address is presented.
  - hs_access=0 -> RELEASE; hs_ready drops on the same edge.
- RELEASE:
  - Exactly one clk.
  - ram_we=0, mux back to CPU, cpu_hold still 1.
  - Next state IDLE, cpu_hold=0 on entry to IDLE.
- hs_access re-asserted in RELEASE: ignored; taken on the following IDLE cycle (minimum one IDLE clk between grants).
- hs_err set by either:
  - hs_write=1 in any state other than GRANT;
  - hs_write=1 in GRANT with hs_address>=RAM_DEPTH.
- hs_err is cleared only by reset.
- hs_data_out holds its last value outside GRANT.
- cpu_hold is glitch-free: it is driven directly from a state register.
- Reset mid-GRANT: ram_we drops asynchronously and the CPU path is restored immediately.

Decomposition:
- Shared package `hiscore_pkg`:
  - enum `hs_port_state_t` {IDLE, DRAIN, GRANT, RELEASE};
  - localparam defaults for ADDR_W and DATA_W, shared with the hiscore engine.
- One natural sub-module, `hs_drain_counter`: ena_6-qualified counter with terminal-count output and synchronous clear.
- The RAM mux stays inline.

Test Plan:
- Idle passthrough: cpu_cs=1, cpu_we=1, cpu_addr=0x123, cpu_wdata=0x5A -> same clk ram_we=1, ram_addr=0x123, ram_wdata=0x5A; cpu_hold=0.
- Grant latency: hs_access rises -> cpu_hold=1 next clk; hs_ready=1 on the clk after the 4th ena_6 pulse. Pulse every 4 clk gives roughly 17 clk.
- Hiscore read/write, in GRANT:
  - write 0xA5 at 0x0F0 -> ram_we pulse with those values.
  - read 0x0F0 -> hs_data_out=0xA5 exactly 2 clk after the address is presented.
  - a CPU cpu_we=1 during GRANT -> ram_we follows hs_write only.
- Abort and release:
  - hs_access drops after 2 ena_6 in DRAIN -> RELEASE 1 clk, IDLE, cpu_hold=0; hs_ready never asserted.
  - from GRANT, hs_access=0 -> hs_ready=0 next clk, cpu_hold=0 two clk later.
- Errors: hs_write=1 in IDLE -> hs_err=1, ram_we=0; in GRANT, hs_address=0xFFF with RAM_DEPTH=2048 -> no write, hs_err=1; hs_err persists until reset_n=0.
- Async reset mid-GRANT: reset_n=0 between clk edges -> ram_we=0, hs_ready=0, cpu_hold=0 immediately; after release, IDLE passthrough works.
